// File: rtl/alu_wb_buffer_pkg.sv
// Shared constants for the ALU / writeback buffer / register-file path.
// Flag bit positions are common to alu, alu_wb_buffer and reg_file.
package alu_wb_buffer_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/alu_wb_buffer_wb_fifo_mem.sv
// Entry storage for the writeback buffer.
// Synchronous write, asynchronous read, no reset on contents.
module wb_fifo_mem
    import alu_wb_buffer_pkg::*;
#(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted entry into its slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_wb_buffer.sv
// ALU result buffer feeding register-file writeback.
// First-word-fall-through FIFO with sticky overflow and occupancy.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = alu_wb_buffer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = alu_wb_buffer_pkg::REG_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_result,
    input  logic                    in_zero,
    input  logic                    in_carry,
    input  logic                    in_overflow,
    input  logic [ADDR_WIDTH-1:0]   in_rd,
    input  logic                    in_wen,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic [ADDR_WIDTH-1:0]   out_rd,
    output logic                    out_wen,
    output logic [2:0]              out_flags,
    output logic                    sticky_ovf,
    input  logic                    sticky_clr,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENT_W   = DATA_WIDTH + ADDR_WIDTH + 4;
    localparam int FLG_LSB = DATA_WIDTH;
    localparam int RD_LSB  = DATA_WIDTH + 3;
    localparam int WEN_BIT = DATA_WIDTH + 3 + ADDR_WIDTH;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             sticky_q, sticky_d;

    logic             push;
    logic             pop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;
    logic             head_wen;

    assign in_ready  = (occ_q != FULL_CNT);
    assign out_valid = (occ_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_entry = {in_wen, in_rd, in_overflow,
                       in_carry, in_zero, in_result};

    wb_fifo_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Head entry fields; x0 and an empty buffer never write
    always_comb begin
        out_result = head[DATA_WIDTH-1:0];
        out_rd     = head[RD_LSB +: ADDR_WIDTH];
        head_wen   = head[WEN_BIT];
        out_flags  = '0;
        out_flags[FLAG_ZERO]  = head[FLG_LSB + FLAG_ZERO];
        out_flags[FLAG_CARRY] = head[FLG_LSB + FLAG_CARRY];
        out_flags[FLAG_OVF]   = head[FLG_LSB + FLAG_OVF];
        out_wen = out_valid & head_wen & (out_rd != '0);
    end

    assign sticky_ovf = sticky_q;
    assign occupancy  = occ_q;

    // Next pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        sticky_d = (sticky_q & ~sticky_clr) | (push & in_overflow);
    end

    // Control state registers; reset drops all entries
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sticky_q <= sticky_d;
        end
    end

endmodule
